// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_idx;
   logic            flush;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic [4:0]      resp_rd;
   logic            busy;

   modport master (
      output req_valid, funct3, op_a, op_b, rd_idx, flush, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_rd, busy
   );

   modport slave (
      input  req_valid, funct3, op_a, op_b, rd_idx, flush, resp_ready,
      output req_ready, resp_valid, resp_data, resp_rd, busy
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per
// cycle on magnitudes, sign fix-up at the end, valid/ready response.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_unit_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
   state_t r_state, w_next;

   logic [2*XLEN-1:0] r_prod;
   logic [XLEN-1:0]   r_m;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_f3;
   logic              r_neg;
   logic [XLEN-1:0]   r_resp_data;
   logic [4:0]        r_resp_rd;

   logic              w_sgn_a, w_sgn_b, w_sa, w_sb;
   logic              w_is_div, w_is_rem, w_div0, w_ovf, w_accept;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res;
   logic [XLEN:0]     w_sum, w_shift;
   logic [XLEN-1:0]   w_diff, w_rem, w_fix_res;
   logic              w_ge;
   logic [2*XLEN-1:0] w_step, w_prod_fix;

   assign w_sgn_a  = !(bus.funct3 inside {3'b011, 3'b101, 3'b111});
   assign w_sgn_b  = w_sgn_a && (bus.funct3 != 3'b010);
   assign w_sa     = w_sgn_a & bus.op_a[XLEN-1];
   assign w_sb     = w_sgn_b & bus.op_b[XLEN-1];
   assign w_mag_a  = w_sa ? -bus.op_a : bus.op_a;
   assign w_mag_b  = w_sb ? -bus.op_b : bus.op_b;
   assign w_is_div = bus.funct3[2];
   assign w_is_rem = bus.funct3[2] & bus.funct3[1];
   assign w_div0   = w_is_div && (bus.op_b == '0);
   assign w_ovf    = w_is_div && !bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
   assign w_accept = (r_state == S_IDLE) && bus.req_valid && !bus.flush;

   always_comb begin
      w_spec_res = w_is_rem ? bus.op_a : '1;
      if (w_ovf) w_spec_res = w_is_rem ? '0 : MIN_NEG;
   end

   // Multiply keeps the multiplier in the low half and shifts right;
   // divide keeps remainder:quotient and shifts left.
   assign w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_m} : '0);
   assign w_shift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
   assign w_ge    = (w_shift >= {1'b0, r_m});
   assign w_diff  = w_shift[XLEN-1:0] - r_m;

   always_comb begin
      if (r_f3[2])
         w_step = w_ge ? {w_diff, r_prod[XLEN-2:0], 1'b1}
                       : {w_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
      else
         w_step = {w_sum, r_prod[XLEN-1:1]};
   end

   // Negating the full register also yields the negated quotient in its low half.
   assign w_prod_fix = r_neg ? -r_prod : r_prod;
   assign w_rem      = r_neg ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];

   always_comb begin
      case (r_f3)
         3'b000, 3'b100, 3'b101: w_fix_res = w_prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         default:                w_fix_res = w_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (bus.flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (bus.req_valid) w_next = (w_div0 || w_ovf) ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (bus.resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod      <= '0;
         r_m         <= '0;
         r_cnt       <= '0;
         r_f3        <= '0;
         r_neg       <= 1'b0;
         r_resp_data <= '0;
         r_resp_rd   <= '0;
      end else if (w_accept) begin
         r_f3      <= bus.funct3;
         r_resp_rd <= bus.rd_idx;
         r_neg     <= w_is_rem ? w_sa : (w_sa ^ w_sb);
         r_cnt     <= CW'(XLEN-1);
         r_m       <= w_is_div ? w_mag_b : w_mag_a;
         r_prod    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
         if (w_div0 || w_ovf) r_resp_data <= w_spec_res;
      end else if (r_state == S_CALC) begin
         r_prod <= w_step;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end else if (r_state == S_FIX) begin
         r_resp_data <= w_fix_res;
      end
   end

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.resp_valid = (r_state == S_DONE);
   assign bus.resp_data  = r_resp_data;
   assign bus.resp_rd    = r_resp_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, back-pressure, flush, reset.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   muldiv_unit_if #(.XLEN(32)) bus ();
   muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      bus.req_valid = 1'b1;
      bus.funct3    = f3;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.rd_idx    = rd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int unsigned exp_lat, input int unsigned hold);
      int unsigned lat;
      check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
      issue(f3, a, b, rd);
      lat = 1;
      while (!bus.resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "/latency"}, lat, exp_lat);
      check({tag, "/data"}, bus.resp_data, exp);
      check({tag, "/rd"}, 32'(bus.resp_rd), 32'(rd));
      for (int i = 0; i < int'(hold); i++) begin
         @(posedge clk); #1;
         check({tag, "/hold_valid"}, 32'(bus.resp_valid), 32'd1);
         check({tag, "/hold_data"}, bus.resp_data, exp);
         check({tag, "/hold_rd"}, 32'(bus.resp_rd), 32'(rd));
         check({tag, "/hold_req_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check({tag, "/ready_after"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      logic seen;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.funct3     = 3'b000;
      bus.op_a       = '0;
      bus.op_b       = '0;
      bus.rd_idx     = '0;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst/busy", 32'(bus.busy), 32'd0);
      check("rst/req_ready", 32'(bus.req_ready), 32'd1);
      check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst/resp_data", bus.resp_data, 32'd0);
      check("rst/resp_rd", 32'(bus.resp_rd), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 34, 0);
      do_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 34, 0);
      do_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 34, 0);
      do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 34, 0);
      do_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 34, 0);
      do_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 34, 0);
      do_op("divu",   3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       34, 0);
      do_op("remu",   3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        34, 0);
      do_op("div_pn", 3'b100, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 34, 0);
      do_op("rem_pn", 3'b110, 32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        34, 0);

      do_op("div0",    3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1, 0);
      do_op("remu0",   3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1, 0);
      do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1, 0);
      do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1, 0);

      do_op("bp_mul", 3'b000, 32'd1000, 32'd1000, 5'd17, 32'd1000000, 34, 5);

      issue(3'b101, 32'd100, 32'd7, 5'd18);
      repeat (9) @(posedge clk);
      #1;
      check("flush/busy_pre", 32'(bus.busy), 32'd1);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("flush/busy", 32'(bus.busy), 32'd0);
      check("flush/req_ready", 32'(bus.req_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) seen = 1'b1;
      end
      check("flush/no_resp", 32'(seen), 32'd0);

      bus.req_valid = 1'b1;
      bus.funct3    = 3'b100;
      bus.op_a      = 32'd5;
      bus.op_b      = 32'd0;
      bus.flush     = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      check("flush_idle/busy", 32'(bus.busy), 32'd0);
      check("flush_idle/resp_valid", 32'(bus.resp_valid), 32'd0);

      do_op("post_flush", 3'b101, 32'd100, 32'd7, 5'd19, 32'd14, 34, 0);

      issue(3'b000, 32'd3, 32'd5, 5'd20);
      repeat (5) @(posedge clk);
      #2;
      check("mid_rst/busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst/busy", 32'(bus.busy), 32'd0);
      check("mid_rst/req_ready", 32'(bus.req_ready), 32'd1);
      check("mid_rst/resp_valid", 32'(bus.resp_valid), 32'd0);
      check("mid_rst/resp_data", bus.resp_data, 32'd0);
      check("mid_rst/resp_rd", 32'(bus.resp_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("post_rst", 3'b000, 32'd3, 32'd5, 5'd21, 32'd15, 34, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
